linebuf_scheduler: RTL and testbench

- Sequences a ring of N_BUF line buffers between the input buffer controller (writer) and the downstream line consumer (reader).
- Tracks which buffer the writer fills next and queues completed lines, with line index and end-of-frame tag, for the reader.
- Detects writer overrun and counts dropped lines and completed frames.
- Sits in the pclk domain between the input buffer controller's line_valid/frame_valid pulses and the processing core.

---
 rtl/linebuf_scheduler_if.sv | 35 +++
 rtl/linebuf_scheduler.sv | 149 ++++++++++++++
 tb/tb_linebuf_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/linebuf_scheduler_if.sv
// Handshake bundle between the line writer, the scheduler and the line reader.
// The scheduler takes the slave side; the writer/reader environment takes master.
interface linebuf_scheduler_if #(
  parameter int N_BUF  = 2,
  parameter int LINE_W = 11,
  parameter int CNT_W  = 16
);
  localparam int BUF_W = $clog2(N_BUF);

  logic              line_valid;
  logic              frame_valid;
  logic [BUF_W-1:0]  wr_buf;
  logic              rd_valid;
  logic [BUF_W-1:0]  rd_buf;
  logic [LINE_W-1:0] rd_line;
  logic              rd_last;
  logic              rd_done;
  logic [BUF_W:0]    occupancy;
  logic              overflow;
  logic              clr_overflow;
  logic [CNT_W-1:0]  lines_dropped;
  logic [CNT_W-1:0]  frame_cnt;

  modport slave (
    input  line_valid, frame_valid, rd_done, clr_overflow,
    output wr_buf, rd_valid, rd_buf, rd_line, rd_last,
           occupancy, overflow, lines_dropped, frame_cnt
  );

  modport master (
    output line_valid, frame_valid, rd_done, clr_overflow,
    input  wr_buf, rd_valid, rd_buf, rd_line, rd_last,
           occupancy, overflow, lines_dropped, frame_cnt
  );
endinterface

// File: rtl/linebuf_scheduler.sv
// Ring scheduler for N_BUF line buffers: hands the writer its next buffer and
// queues completed lines (buffer, line index, end-of-frame) for the reader.
module linebuf_scheduler #(
  parameter int N_BUF  = 2,
  parameter int LINE_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic pclk,
  input  logic reset_n,
  linebuf_scheduler_if.slave bus
);
  localparam int BUF_W = $clog2(N_BUF);

  typedef enum logic {S_EMPTY, S_AVAIL} state_t;

  state_t            r_state;
  logic [BUF_W-1:0]  r_wr_buf;
  logic [BUF_W-1:0]  r_head;
  logic [BUF_W-1:0]  r_tail;
  logic [BUF_W:0]    r_occ;
  logic [BUF_W-1:0]  r_rd_buf;
  logic [LINE_W-1:0] r_rd_line;
  logic              r_rd_last;
  logic [LINE_W-1:0] r_line;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_dropped;
  logic [CNT_W-1:0]  r_frame_cnt;

  // Storage has N_BUF slots so the pointers wrap naturally; the full test caps
  // the live entries at N_BUF-1 because the writer always owns one buffer.
  logic [BUF_W-1:0]  r_q_buf  [N_BUF];
  logic [LINE_W-1:0] r_q_line [N_BUF];
  logic              r_q_last [N_BUF];

  logic              w_pop;
  logic              w_full;
  logic              w_push;
  logic              w_drop;
  logic              w_load;
  logic [BUF_W-1:0]  w_next_head;
  logic [BUF_W:0]    w_occ_nxt;
  logic [BUF_W-1:0]  w_head_buf;
  logic [LINE_W-1:0] w_head_line;
  logic              w_head_last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign w_pop       = bus.rd_done && (r_state == S_AVAIL);
  assign w_full      = (r_occ == (BUF_W+1)'(N_BUF - 1));
  assign w_push      = bus.line_valid && (!w_full || w_pop);
  assign w_drop      = bus.line_valid && !w_push;
  assign w_next_head = w_pop ? r_head + 1'b1 : r_head;

  // Head registers only reload when the head entry actually changes, so they
  // stay stable while the reader works and hold their last value once drained.
  assign w_load = w_push ? ((r_occ == '0) || w_pop)
                         : (w_pop && (r_occ > (BUF_W+1)'(1)));

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + 1'b1;
      2'b01:   w_occ_nxt = r_occ - 1'b1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  // The new head is the entry being pushed this cycle when it lands on the
  // slot the head is moving to; otherwise it is already in storage.
  always_comb begin
    w_head_buf  = r_q_buf[w_next_head];
    w_head_line = r_q_line[w_next_head];
    w_head_last = r_q_last[w_next_head];
    if (w_push && (r_tail == w_next_head)) begin
      w_head_buf  = r_wr_buf;
      w_head_line = r_line;
      w_head_last = bus.frame_valid;
    end
  end

  always_ff @(posedge pclk) begin
    if (w_push) begin
      r_q_buf[r_tail]  <= r_wr_buf;
      r_q_line[r_tail] <= r_line;
      r_q_last[r_tail] <= bus.frame_valid;
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_EMPTY;
      r_wr_buf    <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_occ       <= '0;
      r_rd_buf    <= '0;
      r_rd_line   <= '0;
      r_rd_last   <= 1'b0;
      r_line      <= '0;
      r_overflow  <= 1'b0;
      r_dropped   <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        S_EMPTY: if (w_push) r_state <= S_AVAIL;
        S_AVAIL: if (w_pop && (r_occ == (BUF_W+1)'(1)) && !w_push) r_state <= S_EMPTY;
        default: r_state <= S_EMPTY;
      endcase

      r_occ  <= w_occ_nxt;
      r_head <= w_next_head;
      if (w_push) begin
        r_tail   <= r_tail + 1'b1;
        r_wr_buf <= r_wr_buf + 1'b1;
      end

      if (w_load) begin
        r_rd_buf  <= w_head_buf;
        r_rd_line <= w_head_line;
        r_rd_last <= w_head_last;
      end

      if (bus.frame_valid)     r_line <= '0;
      else if (bus.line_valid) r_line <= r_line + 1'b1;

      if (bus.frame_valid) r_frame_cnt <= r_frame_cnt + 1'b1;

      if (w_drop) begin
        r_overflow <= 1'b1;
        r_dropped  <= sat_inc(r_dropped);
      end else if (bus.clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign bus.wr_buf        = r_wr_buf;
  assign bus.rd_valid      = (r_state == S_AVAIL);
  assign bus.rd_buf        = r_rd_buf;
  assign bus.rd_line       = r_rd_line;
  assign bus.rd_last       = r_rd_last;
  assign bus.occupancy     = r_occ;
  assign bus.overflow      = r_overflow;
  assign bus.lines_dropped = r_dropped;
  assign bus.frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_linebuf_scheduler.sv
// Directed bench for linebuf_scheduler: a vector table on a 2-buffer ring,
// a full 480-line frame on a 4-buffer ring, and an asynchronous mid-frame reset.
module tb_linebuf_scheduler;
  logic pclk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 pclk = ~pclk;

  linebuf_scheduler_if #(.N_BUF(2), .LINE_W(11), .CNT_W(16)) i2 ();
  linebuf_scheduler_if #(.N_BUF(4), .LINE_W(11), .CNT_W(16)) i4 ();

  linebuf_scheduler #(.N_BUF(2), .LINE_W(11), .CNT_W(16)) u_dut2 (
    .pclk(pclk), .reset_n(reset_n), .bus(i2.slave));
  linebuf_scheduler #(.N_BUF(4), .LINE_W(11), .CNT_W(16)) u_dut4 (
    .pclk(pclk), .reset_n(reset_n), .bus(i4.slave));

  typedef struct {
    logic        lv, fv, rdd, clr;
    logic [0:0]  wb;
    logic        rv;
    logic [0:0]  rb;
    logic [10:0] rl;
    logic        last;
    logic [1:0]  occ;
    logic        ovf;
    logic [15:0] drop;
    logic [15:0] fc;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input int lv, input int fv, input int rdd, input int clr,
                              input int wb, input int rv, input int rb, input int rl,
                              input int last, input int occ, input int ovf,
                              input int drop, input int fc);
    vec_t v;
    v.lv = lv[0];   v.fv = fv[0];   v.rdd = rdd[0]; v.clr = clr[0];
    v.wb = wb[0:0]; v.rv = rv[0];   v.rb = rb[0:0]; v.rl = 11'(rl);
    v.last = last[0]; v.occ = 2'(occ); v.ovf = ovf[0];
    v.drop = 16'(drop); v.fc = 16'(fc);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_line;
    i2.line_valid = 0; i2.frame_valid = 0; i2.rd_done = 0; i2.clr_overflow = 0;
    i4.line_valid = 0; i4.frame_valid = 0; i4.rd_done = 0; i4.clr_overflow = 0;

    //            lv fv rd cl  wb rv rb rl la oc ov dr fc
    vecs[0]  = mk(1, 0, 0, 0,  1, 1, 0, 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0,  1, 1, 0, 0, 0, 1, 1, 1, 0);
    vecs[2]  = mk(1, 0, 0, 0,  1, 1, 0, 0, 0, 1, 1, 2, 0);
    vecs[3]  = mk(0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 2, 0);
    vecs[4]  = mk(0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 2, 0);
    vecs[5]  = mk(1, 0, 0, 0,  0, 1, 1, 3, 0, 1, 0, 2, 0);
    vecs[6]  = mk(1, 0, 1, 0,  1, 1, 0, 4, 0, 1, 0, 2, 0);
    vecs[7]  = mk(1, 0, 0, 1,  1, 1, 0, 4, 0, 1, 1, 3, 0);
    vecs[8]  = mk(0, 0, 0, 1,  1, 1, 0, 4, 0, 1, 0, 3, 0);
    vecs[9]  = mk(1, 1, 1, 0,  0, 1, 1, 6, 1, 1, 0, 3, 1);
    vecs[10] = mk(0, 1, 0, 0,  0, 1, 1, 6, 1, 1, 0, 3, 2);
    vecs[11] = mk(0, 0, 1, 0,  0, 0, 1, 6, 1, 0, 0, 3, 2);
    vecs[12] = mk(0, 0, 1, 0,  0, 0, 1, 6, 1, 0, 0, 3, 2);
    vecs[13] = mk(1, 0, 0, 0,  1, 1, 0, 0, 0, 1, 0, 3, 2);

    repeat (3) @(posedge pclk);
    #1 reset_n = 1'b1;
    tick();

    chk("reset wr_buf",    32'(i2.wr_buf), 0);
    chk("reset rd_valid",  32'(i2.rd_valid), 0);
    chk("reset occupancy", 32'(i2.occupancy), 0);
    chk("reset overflow",  32'(i2.overflow), 0);
    chk("reset dropped",   32'(i2.lines_dropped), 0);
    chk("reset frame_cnt", 32'(i2.frame_cnt), 0);

    for (int i = 0; i < 14; i++) begin
      i2.line_valid   = vecs[i].lv;
      i2.frame_valid  = vecs[i].fv;
      i2.rd_done      = vecs[i].rdd;
      i2.clr_overflow = vecs[i].clr;
      tick();
      chk($sformatf("v%0d wr_buf", i),    32'(i2.wr_buf),        32'(vecs[i].wb));
      chk($sformatf("v%0d rd_valid", i),  32'(i2.rd_valid),      32'(vecs[i].rv));
      chk($sformatf("v%0d rd_buf", i),    32'(i2.rd_buf),        32'(vecs[i].rb));
      chk($sformatf("v%0d rd_line", i),   32'(i2.rd_line),       32'(vecs[i].rl));
      chk($sformatf("v%0d rd_last", i),   32'(i2.rd_last),       32'(vecs[i].last));
      chk($sformatf("v%0d occupancy", i), 32'(i2.occupancy),     32'(vecs[i].occ));
      chk($sformatf("v%0d overflow", i),  32'(i2.overflow),      32'(vecs[i].ovf));
      chk($sformatf("v%0d dropped", i),   32'(i2.lines_dropped), 32'(vecs[i].drop));
      chk($sformatf("v%0d frame_cnt", i), 32'(i2.frame_cnt),     32'(vecs[i].fc));
    end
    i2.line_valid = 0; i2.frame_valid = 0; i2.rd_done = 0; i2.clr_overflow = 0;

    // 480-line frame on the 4-buffer ring, then the first line of the next frame.
    fork
      begin
        for (int n = 0; n < 481; n++) begin
          i4.line_valid  = 1'b1;
          i4.frame_valid = (n == 479);
          tick();
          i4.line_valid  = 1'b0;
          i4.frame_valid = 1'b0;
          repeat (3) tick();
        end
      end
      begin
        for (int n = 0; n < 481; n++) begin
          int t;
          t = 0;
          while (i4.rd_valid !== 1'b1 && t < 100) begin
            tick();
            t++;
          end
          if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL frame rd_valid timeout waiting for line %0d", n);
            break;
          end
          exp_line = (n == 480) ? 32'd0 : 32'(n);
          chk($sformatf("frame rd_line n%0d", n), 32'(i4.rd_line), exp_line);
          chk($sformatf("frame rd_last n%0d", n), 32'(i4.rd_last), (n == 479) ? 32'd1 : 32'd0);
          tick();
          i4.rd_done = 1'b1;
          tick();
          i4.rd_done = 1'b0;
        end
      end
    join
    chk("frame frame_cnt", 32'(i4.frame_cnt), 1);
    chk("frame overflow",  32'(i4.overflow), 0);
    chk("frame dropped",   32'(i4.lines_dropped), 0);
    chk("frame occupancy", 32'(i4.occupancy), 0);

    // Two lines queued (next-frame lines 1 and 2), then asynchronous reset mid-cycle.
    i4.line_valid = 1'b1;
    tick();
    tick();
    i4.line_valid = 1'b0;
    chk("pre-reset occupancy", 32'(i4.occupancy), 2);
    chk("pre-reset rd_line",   32'(i4.rd_line), 1);
    @(negedge pclk);
    reset_n = 1'b0;
    #1;
    chk("async wr_buf",    32'(i4.wr_buf), 0);
    chk("async occupancy", 32'(i4.occupancy), 0);
    chk("async rd_valid",  32'(i4.rd_valid), 0);
    chk("async rd_buf",    32'(i4.rd_buf), 0);
    chk("async rd_line",   32'(i4.rd_line), 0);
    chk("async rd_last",   32'(i4.rd_last), 0);
    chk("async overflow",  32'(i4.overflow), 0);
    chk("async dropped",   32'(i4.lines_dropped), 0);
    chk("async frame_cnt", 32'(i4.frame_cnt), 0);
    tick();
    reset_n = 1'b1;
    i4.line_valid = 1'b1;
    tick();
    i4.line_valid = 1'b0;
    chk("post-reset rd_valid", 32'(i4.rd_valid), 1);
    chk("post-reset rd_buf",   32'(i4.rd_buf), 0);
    chk("post-reset rd_line",  32'(i4.rd_line), 0);
    chk("post-reset wr_buf",   32'(i4.wr_buf), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end
endmodule
